// File: rtl/word_packer.sv
// word_packer: packs 4-lane masked word vectors into dense 4-word lines
// and queues them in a line FIFO for the memory writer.
module word_packer #(
  parameter int unsigned W          = 64,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_MARGIN  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              last_input_in,
  input  logic [3:0]        word_in_valid,
  input  logic [3:0][W-1:0] word_in,
  output logic              in_almost_full,
  output logic              line_out_valid,
  input  logic              line_out_ready,
  output logic [3:0][W-1:0] line_out,
  output logic [3:0]        line_out_mask,
  output logic              line_out_last,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {ACCUM, FLUSH, DONE} state_t;

  state_t state, state_n;

  logic [1:0]        r, r_n;
  logic [2:0][W-1:0] res, res_n;

  logic [3:0][W-1:0] mem_line [FIFO_DEPTH];
  logic [3:0]        mem_mask [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_n;

  logic [3:0][W-1:0] in_c;
  logic [2:0]        k, t;
  logic [6:0][W-1:0] cat;

  logic              push_req, push_ok, pop, full, in_err;
  logic [3:0][W-1:0] push_line;
  logic [3:0]        push_mask;
  logic              push_last;

  function automatic logic [3:0] mask_of(input logic [2:0] n);
    logic [3:0] m;
    case (n)
      3'd0:    m = 4'b0000;
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Residual words followed by the compacted valid input words; unused slots
  // stay zero so partial lines and the next residual come out zero-filled.
  always_comb begin
    in_c = '0;
    k    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (word_in_valid[i]) begin
        in_c[k[1:0]] = word_in[i];
        k            = k + 3'd1;
      end
    end
    t   = {1'b0, r} + k;
    cat = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (2'(i) < r) cat[i] = res[i];
    end
    for (int unsigned j = 0; j < 4; j++) begin
      if (3'(j) < k) cat[{1'b0, r} + 3'(j)] = in_c[j];
    end
  end

  always_comb begin
    state_n   = state;
    r_n       = r;
    res_n     = res;
    push_req  = 1'b0;
    push_line = '0;
    push_mask = '0;
    push_last = 1'b0;
    in_err    = 1'b0;
    done      = 1'b0;
    unique case (state)
      ACCUM: begin
        if (last_input_in) begin
          push_req  = 1'b1;
          push_line = cat[3:0];
          push_mask = mask_of(t);
          push_last = (t <= 3'd4);
          if (t > 3'd4) begin
            r_n     = 2'(t - 3'd4);
            res_n   = cat[6:4];
            state_n = FLUSH;
          end else begin
            r_n     = '0;
            res_n   = '0;
            state_n = DONE;
          end
        end else if (t >= 3'd4) begin
          push_req  = 1'b1;
          push_line = cat[3:0];
          push_mask = 4'b1111;
          r_n       = 2'(t - 3'd4);
          res_n     = cat[6:4];
        end else begin
          r_n   = t[1:0];
          res_n = cat[2:0];
        end
      end
      FLUSH: begin
        push_req  = 1'b1;
        push_line = {{W{1'b0}}, res};
        push_mask = mask_of({1'b0, r});
        push_last = 1'b1;
        r_n       = '0;
        res_n     = '0;
        state_n   = DONE;
        in_err    = (|word_in_valid) | last_input_in;
      end
      DONE: begin
        in_err = (|word_in_valid) | last_input_in;
        if (count == '0) begin
          done    = 1'b1;
          state_n = ACCUM;
        end
      end
      default: state_n = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACCUM;
      r     <= '0;
      res   <= '0;
    end else begin
      state <= state_n;
      r     <= r_n;
      res   <= res_n;
    end
  end

  // A pop frees the full slot in the same cycle, so push-at-full still lands.
  assign full           = (count == CW'(FIFO_DEPTH));
  assign line_out_valid = (count != '0);
  assign pop            = line_out_valid & line_out_ready;
  assign push_ok        = push_req & (~full | pop);
  assign line_out       = line_out_valid ? mem_line[rd_ptr] : '0;
  assign line_out_mask  = line_out_valid ? mem_mask[rd_ptr] : '0;
  assign line_out_last  = line_out_valid ? mem_last[rd_ptr] : 1'b0;

  always_comb count_n = count + CW'(push_ok) - CW'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      in_almost_full <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count          <= count_n;
      in_almost_full <= (CW'(FIFO_DEPTH) - count_n) <= CW'(AF_MARGIN);
      overflow       <= overflow | in_err | (push_req & ~push_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_line[wr_ptr] <= push_line;
      mem_mask[wr_ptr] <= push_mask;
      mem_last[wr_ptr] <= push_last;
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// Scoreboard bench for word_packer.
module tb_word_packer;

  typedef struct packed {
    logic [3:0][63:0] line;
    logic [3:0]       mask;
    logic             last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             last_input_in;
  logic [3:0]       word_in_valid;
  logic [3:0][63:0] word_in;
  logic             in_almost_full;
  logic             line_out_valid;
  logic             line_out_ready;
  logic [3:0][63:0] line_out;
  logic [3:0]       line_out_mask;
  logic             line_out_last;
  logic             done;
  logic             overflow;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   base;
  exp_t exp_q[$];
  int   pop_cyc[$];
  exp_t e;

  localparam logic [63:0] X = 64'hDEAD;

  word_packer #(.W(64), .FIFO_DEPTH(8), .AF_MARGIN(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .last_input_in  (last_input_in),
    .word_in_valid  (word_in_valid),
    .word_in        (word_in),
    .in_almost_full (in_almost_full),
    .line_out_valid (line_out_valid),
    .line_out_ready (line_out_ready),
    .line_out       (line_out),
    .line_out_mask  (line_out_mask),
    .line_out_last  (line_out_last),
    .done           (done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [271:0] act, input logic [271:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted line is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst && line_out_valid && line_out_ready) begin
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_line: got line=%0h mask=%b last=%b expected none",
                 line_out, line_out_mask, line_out_last);
      end else begin
        e = exp_q.pop_front();
        chk("line", {line_out, line_out_mask, line_out_last}, {e.line, e.mask, e.last});
      end
    end
  end

  task automatic expect_line(input logic [63:0] a, b, c, d, input logic [3:0] m, input logic l);
    exp_t x;
    x.line[0] = a;
    x.line[1] = b;
    x.line[2] = c;
    x.line[3] = d;
    x.mask    = m;
    x.last    = l;
    exp_q.push_back(x);
  endtask

  task automatic send(input logic [3:0] m, input logic [63:0] a, b, c, d, input logic l);
    word_in_valid = m;
    word_in[0]    = a;
    word_in[1]    = b;
    word_in[2]    = c;
    word_in[3]    = d;
    last_input_in = l;
    @(posedge clk); #1;
    word_in_valid = '0;
    word_in       = '0;
    last_input_in = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int unsigned n    = 0;
    bit          seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    chk({name, "_done"}, seen, 1);
    chk({name, "_drain"}, exp_q.size(), 0);
    @(negedge clk);
    chk({name, "_done_pulse"}, done, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #6;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    rst            = 1'b0;
    line_out_ready = 1'b0;
    word_in_valid  = '0;
    word_in        = '0;
    last_input_in  = 1'b0;
    #12;
    chk("rst_valid", line_out_valid, 0);
    chk("rst_line", line_out, 0);
    chk("rst_mask", line_out_mask, 0);
    chk("rst_last", line_out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_af", in_almost_full, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Full lanes, with per-line latency
    line_out_ready = 1'b1;
    for (int n = 0; n < 3; n++)
      expect_line(64'(4*n+1), 64'(4*n+2), 64'(4*n+3), 64'(4*n+4), 4'b1111, 1'b0);
    pop_cyc.delete();
    base = cyc;
    for (int n = 0; n < 3; n++)
      send(4'b1111, 64'(4*n+1), 64'(4*n+2), 64'(4*n+3), 64'(4*n+4), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_drain", exp_q.size(), 0);
    chk("t1_pops", pop_cyc.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < pop_cyc.size()) chk("t1_latency", pop_cyc[i], base + 1 + i);

    // Sparse pack
    expect_line(64'hA, 64'hB, 64'hC, 64'hD, 4'b1111, 1'b0);
    expect_line(64'hE, 64'hF, 64'h0, 64'h0, 4'b0011, 1'b1);
    send(4'b0101, 64'hA, X, 64'hB, X, 1'b0);
    send(4'b1110, X, 64'hC, 64'hD, 64'hE, 1'b0);
    send(4'b0001, 64'hF, X, X, X, 1'b1);
    wait_done("t2");

    // Two-push flush (t=7)
    expect_line(64'd1, 64'd2, 64'd3, 64'd4, 4'b1111, 1'b0);
    expect_line(64'd5, 64'd6, 64'd7, 64'd0, 4'b0111, 1'b1);
    send(4'b0111, 64'd1, 64'd2, 64'd3, X, 1'b0);
    send(4'b1111, 64'd4, 64'd5, 64'd6, 64'd7, 1'b1);
    wait_done("t3");

    // Last with exactly four words
    expect_line(64'h11, 64'h12, 64'h13, 64'h14, 4'b1111, 1'b1);
    send(4'b1010, X, 64'h11, X, 64'h12, 1'b0);
    send(4'b1001, 64'h13, X, X, 64'h14, 1'b1);
    wait_done("t3b");

    // Empty last, held under backpressure; input in DONE sets overflow
    line_out_ready = 1'b0;
    expect_line(64'h0, 64'h0, 64'h0, 64'h0, 4'b0000, 1'b1);
    send(4'b0000, X, X, X, X, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", line_out_valid, 1);
      chk("t4_hold_last", line_out_last, 1);
      chk("t4_no_done", done, 0);
    end
    chk("t4_ovf_pre", overflow, 0);
    @(posedge clk); #1;
    send(4'b0001, 64'h55, X, X, X, 1'b0);
    chk("t4_ovf_done_input", overflow, 1);
    line_out_ready = 1'b1;
    wait_done("t4");

    do_reset();
    chk("t5_ovf_cleared", overflow, 0);

    // Backpressure, almost-full and full-FIFO overflow
    line_out_ready = 1'b0;
    for (int n = 0; n < 9; n++) begin
      if (n < 8)
        expect_line(64'(4*n+1), 64'(4*n+2), 64'(4*n+3), 64'(4*n+4), 4'b1111, 1'b0);
      send(4'b1111, 64'(4*n+1), 64'(4*n+2), 64'(4*n+3), 64'(4*n+4), 1'b0);
      chk("t5_af", in_almost_full, (n + 1 >= 6));
      chk("t5_ovf", overflow, (n == 8));
    end
    line_out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_drain", exp_q.size(), 0);
    chk("t5_af_low", in_almost_full, 0);
    chk("t5_empty", line_out_valid, 0);
    chk("t5_ovf_sticky", overflow, 1);

    // Async reset mid-stream: 3 queued lines plus a 2-word residual
    line_out_ready = 1'b0;
    for (int n = 0; n < 3; n++)
      send(4'b1111, 64'(256+4*n), 64'(257+4*n), 64'(258+4*n), 64'(259+4*n), 1'b0);
    send(4'b0011, 64'h201, 64'h202, X, X, 1'b0);
    chk("t6_pre_valid", line_out_valid, 1);
    rst = 1'b0;
    #1;
    chk("t6_valid", line_out_valid, 0);
    chk("t6_line", line_out, 0);
    chk("t6_mask", line_out_mask, 0);
    chk("t6_last", line_out_last, 0);
    chk("t6_done", done, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_af", in_almost_full, 0);
    #5;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    line_out_ready = 1'b1;
    expect_line(64'h301, 64'h302, 64'h303, 64'h304, 4'b1111, 1'b0);
    expect_line(64'h305, 64'h0, 64'h0, 64'h0, 4'b0001, 1'b1);
    send(4'b1111, 64'h301, 64'h302, 64'h303, 64'h304, 1'b0);
    send(4'b0100, X, X, 64'h305, X, 1'b1);
    wait_done("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
